// File: rtl/sr_pulse_encoder_if.sv
// Level-in / SR-pulse-out bundle between the encoder and its latch stage.
// master: the encoder (drives the pulse side). slave: the source/latch side.
interface sr_pulse_encoder_if;
  logic       en;
  logic       level_in;
  logic       s_out;
  logic       r_out;
  logic       en_out;
  logic       q_track;
  logic       busy;
  logic [7:0] pulse_cnt;

  modport master (
    input  en,
    input  level_in,
    output s_out,
    output r_out,
    output en_out,
    output q_track,
    output busy,
    output pulse_cnt
  );

  modport slave (
    output en,
    output level_in,
    input  s_out,
    input  r_out,
    input  en_out,
    input  q_track,
    input  busy,
    input  pulse_cnt
  );
endinterface

// File: rtl/sr_pulse_encoder.sv
// Debounced level-to-SR-pulse encoder for the gated SR latch.
//
// state      | meaning
// IDLE_LOW   | latch expected low, waiting for a high level
// QUAL_HIGH  | level high, counting debounce cycles
// PULSE_SET  | driving s_out/en_out for PULSE_LEN cycles
// IDLE_HIGH  | latch expected high, waiting for a low level
// QUAL_LOW   | level low, counting debounce cycles
// PULSE_RST  | driving r_out/en_out for PULSE_LEN cycles
//
// All outputs are registered from the next-state decode so nothing
// combinational reaches the latch from level_in or en.
module sr_pulse_encoder #(
  parameter int DEBOUNCE  = 4,
  parameter int PULSE_LEN = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_pulse_encoder_if.master bus
);

  typedef enum logic [2:0] {
    IDLE_LOW,
    QUAL_HIGH,
    PULSE_SET,
    IDLE_HIGH,
    QUAL_LOW,
    PULSE_RST
  } state_t;

  localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       q_next;
  logic [7:0] pcnt_next;
  logic       s_next, r_next, en_next, busy_next;
  logic       sync1, level_s;

  // Two-flop synchronizer for the asynchronous level input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      level_s <= 1'b0;
    end else begin
      sync1   <= bus.level_in;
      level_s <= sync1;
    end
  end

  // Next-state, shared counter and tracked-latch bookkeeping.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    q_next     = bus.q_track;
    pcnt_next  = bus.pulse_cnt;
    unique case (state)
      IDLE_LOW: begin
        if (level_s && bus.en) begin
          state_next = QUAL_HIGH;
          cnt_next   = 8'd1;
        end
      end
      QUAL_HIGH: begin
        if (!level_s || !bus.en) begin
          state_next = IDLE_LOW;
        end else if (cnt == DEB_LAST) begin
          state_next = PULSE_SET;
          cnt_next   = 8'd1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      PULSE_SET: begin
        if (cnt == PULSE_LAST) begin
          state_next = IDLE_HIGH;
          q_next     = 1'b1;
          pcnt_next  = bus.pulse_cnt + 8'd1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      IDLE_HIGH: begin
        if (!level_s && bus.en) begin
          state_next = QUAL_LOW;
          cnt_next   = 8'd1;
        end
      end
      QUAL_LOW: begin
        if (level_s || !bus.en) begin
          state_next = IDLE_HIGH;
        end else if (cnt == DEB_LAST) begin
          state_next = PULSE_RST;
          cnt_next   = 8'd1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      PULSE_RST: begin
        if (cnt == PULSE_LAST) begin
          state_next = IDLE_LOW;
          q_next     = 1'b0;
          pcnt_next  = bus.pulse_cnt + 8'd1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: state_next = IDLE_LOW;
    endcase
  end

  // Output decode from the next state so the output flops line up with state.
  always_comb begin
    s_next    = (state_next == PULSE_SET);
    r_next    = (state_next == PULSE_RST);
    en_next   = (state_next == PULSE_SET) || (state_next == PULSE_RST);
    busy_next = (state_next != IDLE_LOW) && (state_next != IDLE_HIGH);
  end

  // State, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE_LOW;
      cnt           <= 8'd0;
      bus.s_out     <= 1'b0;
      bus.r_out     <= 1'b0;
      bus.en_out    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.q_track   <= 1'b0;
      bus.pulse_cnt <= 8'd0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      bus.s_out     <= s_next;
      bus.r_out     <= r_next;
      bus.en_out    <= en_next;
      bus.busy      <= busy_next;
      bus.q_track   <= q_next;
      bus.pulse_cnt <= pcnt_next;
    end
  end

endmodule

// File: tb/tb_sr_pulse_encoder.sv
// Scoreboard bench for sr_pulse_encoder: expected pulses are queued when the
// level is driven and matched against pulses captured by a negedge monitor.
module tb_sr_pulse_encoder;
  localparam int D = 4;
  localparam int P = 2;

  typedef struct {
    bit         is_set;
    int         start;
    int         len;
    bit         q;
    logic [7:0] cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];
  logic [7:0] exp_cnt = 8'd0;

  bit in_pulse = 1'b0;
  bit p_set = 1'b0;
  int p_start = 0;
  int p_len = 0;
  bit overlap_seen = 1'b0;

  sr_pulse_encoder_if bus();

  sr_pulse_encoder #(.DEBOUNCE(D), .PULSE_LEN(P)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse capture: records type, start cycle, length and post-pulse state.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_pulse <= 1'b0;
    end else begin
      if (bus.s_out && bus.r_out) overlap_seen <= 1'b1;
      if (!in_pulse && bus.en_out) begin
        in_pulse <= 1'b1;
        p_set    <= bus.s_out;
        p_start  <= cyc;
        p_len    <= 1;
      end else if (in_pulse && bus.en_out) begin
        p_len <= p_len + 1;
      end else if (in_pulse && !bus.en_out) begin
        in_pulse <= 1'b0;
        obs_q.push_back(ev_t'{p_set, p_start, p_len, bus.q_track, bus.pulse_cnt});
      end
    end
  end

  task automatic push_exp(input bit is_set, input int start);
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back(ev_t'{is_set, start, P, is_set, exp_cnt});
  endtask

  // Drive a clean level edge; the pulse is expected D+2 cycles later.
  task automatic drive_level(input bit v);
    @(posedge clk);
    #1 bus.level_in = v;
    push_exp(v, cyc + D + 2);
  endtask

  task automatic get_pair(output ev_t e, output ev_t o, output bit ok);
    int t = 0;
    while (obs_q.size() == 0 && t < 80) begin
      @(negedge clk);
      t++;
    end
    ok = (obs_q.size() != 0) && (exp_q.size() != 0);
    if (ok) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    bus.level_in = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = 8'd0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 bus.level_in = $urandom_range(0, 1);
      bus.en = $urandom_range(0, 1);
      @(negedge clk);
      total++;
      if ({bus.s_out, bus.r_out, bus.en_out, bus.q_track, bus.busy, bus.pulse_cnt} !== 13'd0) begin
        bad++;
        $display("FAIL reset_hold i=%0d got s=%b r=%b e=%b q=%b busy=%b cnt=%0d want all 0",
                 i, bus.s_out, bus.r_out, bus.en_out, bus.q_track, bus.busy, bus.pulse_cnt);
      end
    end
    bus.level_in = 1'b0;
    bus.en = 1'b1;
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({bus.busy, bus.q_track, bus.pulse_cnt} !== 10'd0) begin
      bad++;
      $display("FAIL reset_release got busy=%b q=%b cnt=%0d want 0 0 0",
               bus.busy, bus.q_track, bus.pulse_cnt);
    end
  endtask

  task automatic test_glitch();
    @(posedge clk);
    #1 bus.level_in = 1'b1;
    repeat (D - 1) @(posedge clk);
    #1 bus.level_in = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (obs_q.size() != 0 || bus.q_track !== 1'b0 || bus.pulse_cnt !== 8'd0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL glitch got pulses=%0d q=%b cnt=%0d busy=%b want 0 0 0 0",
               obs_q.size(), bus.q_track, bus.pulse_cnt, bus.busy);
    end
  endtask

  task automatic test_set();
    ev_t e, o;
    bit ok;
    drive_level(1'b1);
    get_pair(e, o, ok);
    total++;
    if (!ok || o.is_set !== e.is_set || o.start !== e.start || o.len !== e.len || o.q !== e.q || o.cnt !== e.cnt) begin
      bad++;
      $display("FAIL set_pulse ok=%b got set=%b start=%0d len=%0d q=%b cnt=%0d want set=%b start=%0d len=%0d q=%b cnt=%0d",
               ok, o.is_set, o.start, o.len, o.q, o.cnt, e.is_set, e.start, e.len, e.q, e.cnt);
    end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL set_idle got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_set_reset();
    ev_t e, o;
    bit ok;
    drive_level(1'b0);
    get_pair(e, o, ok);
    total++;
    if (!ok || o.is_set !== e.is_set || o.start !== e.start || o.len !== e.len || o.q !== e.q || o.cnt !== e.cnt) begin
      bad++;
      $display("FAIL rst_pulse ok=%b got set=%b start=%0d len=%0d q=%b cnt=%0d want set=%b start=%0d len=%0d q=%b cnt=%0d",
               ok, o.is_set, o.start, o.len, o.q, o.cnt, e.is_set, e.start, e.len, e.q, e.cnt);
    end
    total++;
    if (overlap_seen !== 1'b0) begin
      bad++;
      $display("FAIL s_r_overlap got seen=%b want 0", overlap_seen);
    end
  endtask

  // Level held exactly D cycles: set pulse fires; the fall is only
  // qualified once the set pulse has finished.
  task automatic test_min_width();
    ev_t e, o;
    bit ok;
    int c0;
    @(posedge clk);
    #1 bus.level_in = 1'b1;
    c0 = cyc;
    push_exp(1'b1, c0 + D + 2);
    repeat (D) @(posedge clk);
    #1 bus.level_in = 1'b0;
    push_exp(1'b0, c0 + 2 * D + 2 + P);
    for (int i = 0; i < 2; i++) begin
      get_pair(e, o, ok);
      total++;
      if (!ok || o.is_set !== e.is_set || o.start !== e.start || o.len !== e.len || o.q !== e.q || o.cnt !== e.cnt) begin
        bad++;
        $display("FAIL min_width[%0d] ok=%b got set=%b start=%0d len=%0d q=%b cnt=%0d want set=%b start=%0d len=%0d q=%b cnt=%0d",
                 i, ok, o.is_set, o.start, o.len, o.q, o.cnt, e.is_set, e.start, e.len, e.q, e.cnt);
      end
    end
  endtask

  task automatic test_en_gate();
    ev_t e, o;
    bit ok;
    int c1;
    @(posedge clk);
    #1 bus.en = 1'b0;
    bus.level_in = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL en_low_hold got busy=%b pulses=%0d want 0 0", bus.busy, obs_q.size());
    end
    @(posedge clk);
    #1 bus.en = 1'b1;
    c1 = cyc;
    push_exp(1'b1, c1 + D);
    get_pair(e, o, ok);
    total++;
    if (!ok || o.is_set !== e.is_set || o.start !== e.start || o.len !== e.len || o.q !== e.q || o.cnt !== e.cnt) begin
      bad++;
      $display("FAIL en_gate ok=%b got set=%b start=%0d len=%0d q=%b cnt=%0d want set=%b start=%0d len=%0d q=%b cnt=%0d",
               ok, o.is_set, o.start, o.len, o.q, o.cnt, e.is_set, e.start, e.len, e.q, e.cnt);
    end
    drive_level(1'b0);
    get_pair(e, o, ok);
    total++;
    if (!ok || o.is_set !== e.is_set || o.start !== e.start || o.len !== e.len || o.q !== e.q || o.cnt !== e.cnt) begin
      bad++;
      $display("FAIL en_gate_fall ok=%b got set=%b start=%0d len=%0d q=%b cnt=%0d want set=%b start=%0d len=%0d q=%b cnt=%0d",
               ok, o.is_set, o.start, o.len, o.q, o.cnt, e.is_set, e.start, e.len, e.q, e.cnt);
    end
  endtask

  task automatic test_back_to_back_wrap();
    ev_t e, o;
    bit ok;
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      drive_level((i % 2) == 0);
      get_pair(e, o, ok);
      total++;
      if (!ok || o.is_set !== e.is_set || o.start !== e.start || o.len !== e.len || o.q !== e.q || o.cnt !== e.cnt) begin
        bad++;
        $display("FAIL toggle[%0d] ok=%b got set=%b start=%0d len=%0d q=%b cnt=%0d want set=%b start=%0d len=%0d q=%b cnt=%0d",
                 i, ok, o.is_set, o.start, o.len, o.q, o.cnt, e.is_set, e.start, e.len, e.q, e.cnt);
      end
    end
    @(negedge clk);
    total++;
    if (bus.pulse_cnt !== 8'd0 || bus.q_track !== 1'b0) begin
      bad++;
      $display("FAIL wrap got cnt=%0d q=%b want 0 0", bus.pulse_cnt, bus.q_track);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int t = 0;
    @(posedge clk);
    #1 bus.level_in = 1'b1;
    @(negedge clk);
    while (bus.s_out !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (bus.s_out !== 1'b1) begin
      bad++;
      $display("FAIL mid_pulse_start got s_out=%b want 1 within 40 cycles", bus.s_out);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.s_out, bus.en_out, bus.q_track, bus.busy, bus.pulse_cnt} !== 12'd0) begin
      bad++;
      $display("FAIL mid_pulse_reset got s=%b e=%b q=%b busy=%b cnt=%0d want all 0",
               bus.s_out, bus.en_out, bus.q_track, bus.busy, bus.pulse_cnt);
    end
    bus.level_in = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size());
    end
  endtask

  initial begin
    bus.en = 1'b1;
    bus.level_in = 1'b0;
    test_reset();
    test_glitch();
    test_set();
    test_set_reset();
    test_min_width();
    test_en_gate();
    test_back_to_back_wrap();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
